// File: rtl/fifo_dp_ctrl_pkg.sv
// Shared constants for the dual-port-RAM FIFO controller.
// Holds the default geometry used by the top level.
package fifo_dp_ctrl_pkg;
  localparam int DEF_AWIDTH = 8;
  localparam int DEF_DWIDTH = 8;
endpackage

// File: rtl/dpram_hs.sv
// Dual-port RAM with one clock and a registered read on port B.
// q_b only updates on an enabled read, so an issued word stays put until it is consumed.
module dpram_hs #(
  parameter int aWidth = 8,
  parameter int dWidth = 8
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [aWidth-1:0] addr_a,
  input  logic [dWidth-1:0] d_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [aWidth-1:0] addr_b,
  input  logic [dWidth-1:0] d_b,
  output logic [dWidth-1:0] q_b
);
  logic [dWidth-1:0] mem [0:(1<<aWidth)-1];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= d_a;
    if (we_b) mem[addr_b] <= d_b;
    if (en_b && !we_b) q_b <= mem[addr_b];
  end
endmodule

// File: rtl/fifo_dp_ctrl.sv
// Synchronous FIFO around dpram_hs with valid/ready streams and a first-word-fall-through output.
// Read path: RAM word -> q_b (rd_pend) -> rd_data (rd_valid).
//
// Handshake: a word moves on a side exactly in a cycle where its valid and ready are both high at
// the clock edge; valid never depends on ready, and wr_ready depends only on the registered count.
module fifo_dp_ctrl
  import fifo_dp_ctrl_pkg::*;
#(
  parameter int aWidth = DEF_AWIDTH,
  parameter int dWidth = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [dWidth-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [dWidth-1:0] rd_data,
  input  logic              rd_ready,
  output logic [aWidth:0]   count,
  output logic              empty,
  output logic              full
);
  localparam int PW = aWidth + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {aWidth{1'b0}}};

  logic [PW-1:0]     wptr, rptr, ram_words;
  logic              rd_pend;
  logic [dWidth-1:0] q_b;
  logic              wr_fire, rd_fire, rd_load, rd_issue;

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign wr_ready  = !full;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  // Registered wptr only: a word written this cycle is never read in the same cycle.
  assign ram_words = wptr - rptr;
  assign rd_load   = rd_pend && (!rd_valid || rd_fire);
  // q_b may only be refilled when it is empty or its word moves to rd_data at this edge.
  assign rd_issue  = (ram_words != '0) && (!rd_pend || rd_load);

  dpram_hs #(.aWidth(aWidth), .dWidth(dWidth)) u_ram (
    .clk    (clk),
    .we_a   (wr_fire),
    .addr_a (wptr[aWidth-1:0]),
    .d_a    (wr_data),
    .en_b   (rd_issue),
    .we_b   (1'b0),
    .addr_b (rptr[aWidth-1:0]),
    .d_b    ({dWidth{1'b0}}),
    .q_b    (q_b)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_fire)  wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;

      if (rd_issue)     rd_pend <= 1'b1;
      else if (rd_load) rd_pend <= 1'b0;

      if (rd_load) begin
        rd_data  <= q_b;
        rd_valid <= 1'b1;
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
      end

      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_dp_ctrl.sv
// Bench for fifo_dp_ctrl (aWidth=3): directed latency/fill/stream/flush cases plus random stalls,
// all checked against a word queue that models the FIFO contents.
module tb_fifo_dp_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset_n, flush;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          empty, full;

  fifo_dp_ctrl #(.aWidth(AW), .dWidth(DW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .empty(empty), .full(full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_chk = 0;
  int n_bad = 0;
  int n_fire = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: called at a negedge, drives inputs, predicts, returns at the next negedge.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic wf, rf;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    check("wr_ready", wr_ready, exp_q.size() != DEPTH);
    if (exp_q.size() == 0) check("no_underflow", rd_valid, 0);
    else if (rd_valid) check("head", rd_data, exp_q[0]);
    wf = wv && (exp_q.size() != DEPTH);
    rf = rd_valid && rr && (exp_q.size() != 0);
    @(posedge clk);
    if (wf) exp_q.push_back(wd);
    if (rf) begin
      void'(exp_q.pop_front());
      n_fire++;
    end
    @(negedge clk);
    check("count", count, exp_q.size());
    check("empty", empty, exp_q.size() == 0);
    check("full", full, exp_q.size() == DEPTH);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle(1'b0, 8'h00, 1'b1);
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h11; rd_ready = 1'b0;

    // reset held 3 cycles with a write offered
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_ready", wr_ready, 1);
    reset_n = 1'b1;
    wr_valid = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // latency: write at edge N, rd_valid after edge N+2
    cycle(1'b1, 8'hA5, 1'b0);
    check("lat_c0_valid", rd_valid, 0);
    cycle(1'b0, 8'h00, 1'b0);
    check("lat_c1_valid", rd_valid, 0);
    cycle(1'b0, 8'h00, 1'b0);
    check("lat_c2_valid", rd_valid, 1);
    check("lat_c2_data", rd_data, 8'hA5);
    drain();

    // fill to full, offer extra words, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    check("fill_full", full, 1);
    check("fill_wr_ready", wr_ready, 0);
    check("fill_count", count, DEPTH);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    check("full_rd_no_free", count, DEPTH - 1);
    drain();

    // streaming across pointer wrap
    n_fire = 0;
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i * 7 + 3), 1'b1);
    check("stream_rate", n_fire, 297);
    drain();

    // random stalls
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)), $urandom_range(0, 99) < 55);
    drain();

    // flush with 5 words held and a simultaneous write
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    check("pre_flush_count", count, 5);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h33; rd_ready = 1'b1;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_rd_valid", rd_valid, 0);
    cycle(1'b1, 8'h5A, 1'b0);
    check("flush_c0_valid", rd_valid, 0);
    cycle(1'b0, 8'h00, 1'b0);
    check("flush_c1_valid", rd_valid, 0);
    cycle(1'b0, 8'h00, 1'b0);
    check("flush_c2_valid", rd_valid, 1);
    check("flush_c2_data", rd_data, 8'h5A);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
